// File: rtl/cpu_pkg.sv
// Shared types and constants for the memory-port arbiter.
package cpu_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RWAIT,
    RESP
  } arb_state_t;

  // Identity of the requester owning the current transaction.
  typedef enum logic [1:0] {
    REQ_LD,
    REQ_IF,
    REQ_DM
  } req_id_t;

  // Width of the read-latency wait counter (covers MEM_LAT-1 up to 7).
  localparam int unsigned LAT_CNT_W = 3;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector between instruction fetch and data access.
// o_pick is one-hot: bit 0 = IF, bit 1 = DM, all-zero when nobody requests.
module rr_pick2 (
  input  logic       i_req_if,
  input  logic       i_req_dm,
  input  logic       i_prio_dm,
  output logic [1:0] o_pick
);

  // A lone requester always wins; on a tie the side not served last wins.
  always_comb begin
    o_pick = 2'b00;
    if (i_req_if && i_req_dm) begin
      o_pick = i_prio_dm ? 2'b10 : 2'b01;
    end else if (i_req_if) begin
      o_pick = 2'b01;
    end else if (i_req_dm) begin
      o_pick = 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between loader (LD), instruction fetch (IF)
// and data access (DM). LD has fixed priority, IF/DM alternate round-robin.
// One transaction in flight; command outputs are registered and read data
// returns a fixed MEM_LAT cycles after the command.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 19,
  parameter int unsigned ADDR_SIZE = 12,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 LD_REQ,
  input  logic [ADDR_SIZE-1:0] LD_ADDR,
  input  logic [DATA_SIZE-1:0] LD_WDATA,
  output logic                 LD_GNT,
  input  logic                 IF_REQ,
  input  logic [ADDR_SIZE-1:0] IF_ADDR,
  output logic                 IF_GNT,
  output logic                 IF_RVALID,
  input  logic                 DM_REQ,
  input  logic                 DM_WE,
  input  logic [ADDR_SIZE-1:0] DM_ADDR,
  input  logic [DATA_SIZE-1:0] DM_WDATA,
  output logic                 DM_GNT,
  output logic                 DM_RVALID,
  output logic [DATA_SIZE-1:0] RDATA,
  output logic                 MEM_WR_EN,
  output logic [ADDR_SIZE-1:0] MEM_ADDRESS,
  output logic [DATA_SIZE-1:0] MEM_WR_DATA,
  input  logic [DATA_SIZE-1:0] MEM_RDATA,
  output logic                 BUSY
);

  if ((MEM_LAT < 1) || (MEM_LAT > 8)) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be within 1..8");
  end

  arb_state_t           r_state, w_state_d;
  logic [LAT_CNT_W-1:0] r_cnt, w_cnt_d;
  req_id_t              r_owner, w_owner_d;
  logic                 r_prio_dm, w_prio_dm_d;
  logic                 r_ld_gnt, w_ld_gnt_d;
  logic                 r_if_gnt, w_if_gnt_d;
  logic                 r_dm_gnt, w_dm_gnt_d;
  logic                 r_if_rvalid, w_if_rvalid_d;
  logic                 r_dm_rvalid, w_dm_rvalid_d;
  logic [DATA_SIZE-1:0] r_rdata, w_rdata_d;
  logic                 r_mem_wr_en, w_mem_wr_en_d;
  logic [ADDR_SIZE-1:0] r_mem_addr, w_mem_addr_d;
  logic [DATA_SIZE-1:0] r_mem_wdata, w_mem_wdata_d;
  logic [1:0]           w_pick;

  rr_pick2 u_rr_pick2 (
    .i_req_if  (IF_REQ),
    .i_req_dm  (DM_REQ),
    .i_prio_dm (r_prio_dm),
    .o_pick    (w_pick)
  );

  // Next-state and next-output logic; pulses default low, data registers hold.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_owner_d     = r_owner;
    w_prio_dm_d   = r_prio_dm;
    w_ld_gnt_d    = 1'b0;
    w_if_gnt_d    = 1'b0;
    w_dm_gnt_d    = 1'b0;
    w_if_rvalid_d = 1'b0;
    w_dm_rvalid_d = 1'b0;
    w_rdata_d     = r_rdata;
    w_mem_wr_en_d = 1'b0;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;

    case (r_state)
      IDLE: begin
        if (LD_REQ) begin
          // Loader grants leave the IF/DM pointer untouched.
          w_owner_d     = REQ_LD;
          w_mem_addr_d  = LD_ADDR;
          w_mem_wdata_d = LD_WDATA;
          w_mem_wr_en_d = 1'b1;
          w_ld_gnt_d    = 1'b1;
          w_state_d     = CMD;
        end else if (w_pick[0]) begin
          w_owner_d    = REQ_IF;
          w_mem_addr_d = IF_ADDR;
          w_if_gnt_d   = 1'b1;
          w_prio_dm_d  = 1'b1;
          w_state_d    = CMD;
        end else if (w_pick[1]) begin
          w_owner_d     = REQ_DM;
          w_mem_addr_d  = DM_ADDR;
          if (DM_WE) begin
            w_mem_wdata_d = DM_WDATA;
          end
          w_mem_wr_en_d = DM_WE;
          w_dm_gnt_d    = 1'b1;
          w_prio_dm_d   = 1'b0;
          w_state_d     = CMD;
        end
      end
      CMD: begin
        if (r_mem_wr_en) begin
          w_state_d = IDLE;
        end else begin
          w_cnt_d   = LAT_CNT_W'(MEM_LAT - 1);
          w_state_d = RWAIT;
        end
      end
      RWAIT: begin
        if (r_cnt == '0) begin
          w_rdata_d     = MEM_RDATA;
          w_if_rvalid_d = (r_owner == REQ_IF);
          w_dm_rvalid_d = (r_owner == REQ_DM);
          w_state_d     = RESP;
        end else begin
          w_cnt_d = r_cnt - LAT_CNT_W'(1);
        end
      end
      RESP: begin
        w_state_d = IDLE;
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_owner     <= REQ_LD;
      r_prio_dm   <= 1'b0;
      r_ld_gnt    <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_rdata     <= '0;
      r_mem_wr_en <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_owner     <= w_owner_d;
      r_prio_dm   <= w_prio_dm_d;
      r_ld_gnt    <= w_ld_gnt_d;
      r_if_gnt    <= w_if_gnt_d;
      r_dm_gnt    <= w_dm_gnt_d;
      r_if_rvalid <= w_if_rvalid_d;
      r_dm_rvalid <= w_dm_rvalid_d;
      r_rdata     <= w_rdata_d;
      r_mem_wr_en <= w_mem_wr_en_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
    end
  end

  assign LD_GNT      = r_ld_gnt;
  assign IF_GNT      = r_if_gnt;
  assign DM_GNT      = r_dm_gnt;
  assign IF_RVALID   = r_if_rvalid;
  assign DM_RVALID   = r_dm_rvalid;
  assign RDATA       = r_rdata;
  assign MEM_WR_EN   = r_mem_wr_en;
  assign MEM_ADDRESS = r_mem_addr;
  assign MEM_WR_DATA = r_mem_wdata;
  assign BUSY        = (r_state != IDLE);

endmodule
